// File: rtl/switch_debouncer.sv
// Switch/button conditioner: two-flop synchroniser plus per-bit stability counter,
// producing a debounced level and one-cycle rise/fall pulses. Define DEBOUNCE_TICK_EN to count only on SampleTick.
module switch_debouncer #(
    parameter int WIDTH        = 3,
    parameter int STABLE_COUNT = 16,
    parameter int CNT_W        = 5
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Raw,
    input  logic             SampleTick,
    output logic [WIDTH-1:0] Level,
    output logic [WIDTH-1:0] Rise,
    output logic [WIDTH-1:0] Fall
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_COUNT - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic [WIDTH-1:0] level_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;
    logic             count_en;

`ifdef DEBOUNCE_TICK_EN
    assign count_en = SampleTick;
`else
    logic unused_tick;
    assign unused_tick = SampleTick;
    assign count_en    = 1'b1;
`endif

    // Only s2 is safe to compare against Level; s1 may still be metastable.
    always_comb begin
        cnt_next   = cnt;
        level_next = Level;
        rise_next  = '0;
        fall_next  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s2[i] == Level[i]) begin
                cnt_next[i] = '0;
            end else if (count_en) begin
                if (cnt[i] == LAST) begin
                    level_next[i] = s2[i];
                    rise_next[i]  = s2[i];
                    fall_next[i]  = ~s2[i];
                    cnt_next[i]   = '0;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            s1    <= '0;
            s2    <= '0;
            Level <= '0;
            Rise  <= '0;
            Fall  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1    <= Raw;
            s2    <= s1;
            Level <= level_next;
            Rise  <= rise_next;
            Fall  <= fall_next;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer (STABLE_COUNT=4): reset, clean edge, bounce,
// glitch, simultaneous flips, fall, reset mid-count, and tick gating when DEBOUNCE_TICK_EN is set.
module tb_switch_debouncer;

    localparam int WIDTH = 3;
    localparam int SC    = 4;

    logic             CLK;
    logic             Reset;
    logic [WIDTH-1:0] Raw;
    logic             SampleTick;
    logic [WIDTH-1:0] Level;
    logic [WIDTH-1:0] Rise;
    logic [WIDTH-1:0] Fall;

    int checks   = 0;
    int failures = 0;

    // Expected {Level, Rise, Fall} after each edge.
    logic [3*WIDTH-1:0] exp_q[$];

    switch_debouncer #(
        .WIDTH(WIDTH),
        .STABLE_COUNT(SC),
        .CNT_W(5)
    ) dut (
        .CLK(CLK),
        .Reset(Reset),
        .Raw(Raw),
        .SampleTick(SampleTick),
        .Level(Level),
        .Rise(Rise),
        .Fall(Fall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive inputs for one cycle, clock once, compare {Level,Rise,Fall} 1 time unit after the edge.
    task automatic apply(input logic [WIDTH-1:0] raw, input logic rst, input logic tick,
                         input logic [3*WIDTH-1:0] exp, input string tag);
        logic [3*WIDTH-1:0] e;
        Raw        = raw;
        Reset      = rst;
        SampleTick = tick;
        exp_q.push_back(exp);
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        check(tag, 32'({Level, Rise, Fall}), 32'(e));
    endtask

    initial begin
        Raw        = '0;
        Reset      = 1'b1;
        SampleTick = 1'b1;
        #2;

        // Reset held with all switches on
        for (int i = 0; i < 3; i++) apply(3'b111, 1'b1, 1'b1, 9'b000_000_000, "reset_hold");
        apply(3'b111, 1'b0, 1'b1, 9'b000_000_000, "reset_release");
        for (int i = 0; i < 6; i++) apply(3'b000, 1'b0, 1'b1, 9'b000_000_000, "post_reset_idle");

        // Clean edge on bit 0: flips on the 6th edge after the change
        for (int i = 0; i < 8; i++)
            apply(3'b001, 1'b0, 1'b1,
                  (i < 5) ? 9'b000_000_000 : (i == 5) ? 9'b001_001_000 : 9'b001_000_000,
                  "clean_edge");

        // Bounce on bit 1 then held high
        apply(3'b011, 1'b0, 1'b1, 9'b001_000_000, "bounce");
        apply(3'b001, 1'b0, 1'b1, 9'b001_000_000, "bounce");
        apply(3'b011, 1'b0, 1'b1, 9'b001_000_000, "bounce");
        apply(3'b001, 1'b0, 1'b1, 9'b001_000_000, "bounce");
        for (int i = 0; i < 7; i++)
            apply(3'b011, 1'b0, 1'b1,
                  (i < 5) ? 9'b001_000_000 : (i == 5) ? 9'b011_010_000 : 9'b011_000_000,
                  "bounce_settle");

        // Short glitch on bit 2 must be rejected
        for (int i = 0; i < 3; i++) apply(3'b111, 1'b0, 1'b1, 9'b011_000_000, "glitch");
        for (int i = 0; i < 6; i++) apply(3'b011, 1'b0, 1'b1, 9'b011_000_000, "glitch_after");

        // Bits 0 and 1 fall together
        for (int i = 0; i < 7; i++)
            apply(3'b000, 1'b0, 1'b1,
                  (i < 5) ? 9'b011_000_000 : (i == 5) ? 9'b000_000_011 : 9'b000_000_000,
                  "dual_fall");

        // Bits 0 and 2 rise together
        for (int i = 0; i < 7; i++)
            apply(3'b101, 1'b0, 1'b1,
                  (i < 5) ? 9'b000_000_000 : (i == 5) ? 9'b101_101_000 : 9'b101_000_000,
                  "dual_rise");

        // Reset on the 3rd counting edge of a falling bit 0: no Fall ever
        for (int i = 0; i < 4; i++) apply(3'b100, 1'b0, 1'b1, 9'b101_000_000, "midcount_pre");
        apply(3'b000, 1'b1, 1'b1, 9'b000_000_000, "midcount_reset");
        for (int i = 0; i < 8; i++) apply(3'b000, 1'b0, 1'b1, 9'b000_000_000, "midcount_after");

`ifdef DEBOUNCE_TICK_EN
        // Tick every 8th cycle; flip on the 4th tick edge after s2 settles
        for (int i = 0; i < 40; i++)
            apply(3'b001, 1'b0, (i % 8 == 7),
                  (i < 31) ? 9'b000_000_000 : (i == 31) ? 9'b001_001_000 : 9'b001_000_000,
                  "tick_gated");
`else
        // SampleTick must have no effect in the default build
        for (int i = 0; i < 8; i++)
            apply(3'b001, 1'b0, 1'b0,
                  (i < 5) ? 9'b000_000_000 : (i == 5) ? 9'b001_001_000 : 9'b001_000_000,
                  "tick_ignored");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
